// File: rtl/ifetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : ifetch_unit
// Brief   : single-outstanding instruction fetch FSM with decode-stall buffer
// Rev     : 1.0
// ============================================================================
module ifetch_unit #(
    parameter logic [31:0] NOP_INST = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] pc_i,
    input  logic        flush_i,
    input  logic        id_stall_i,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic        stall_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic        inst_valid_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_HOLD    = 2'd2,
        S_DISCARD = 2'd3
    } state_t;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    state_t      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        inst_valid_q, inst_valid_d;
    logic        err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] buf_q, buf_d;
    logic [7:0]  cnt_inc_w;
    logic        timeout_w;
    logic        release_w;

    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        inst_d       = NOP_INST;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = 1'b0;
        err_d        = err_q;
        cnt_d        = cnt_q;
        buf_d        = buf_q;
        release_w    = 1'b0;
        cnt_inc_w    = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        // A no-ack cycle that brings the count to MAX_WAIT abandons the request
        timeout_w    = (cnt_inc_w >= MAX_WAIT_C);

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d    = S_REQ;
                    mem_req_d  = 1'b1;
                    mem_addr_d = pc_i;
                    cnt_d      = 8'd0;
                end
            end
            S_REQ: begin
                if (mem_ack_i) begin
                    mem_req_d = 1'b0;
                    if (flush_i) begin
                        state_d = S_IDLE;
                    end else if (!id_stall_i) begin
                        release_w    = 1'b1;
                        inst_d       = mem_data_i;
                        inst_pc_d    = mem_addr_q;
                        inst_valid_d = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        buf_d   = mem_data_i;
                        state_d = S_HOLD;
                    end
                end else begin
                    cnt_d = cnt_inc_w;
                    if (timeout_w) begin
                        err_d     = 1'b1;
                        mem_req_d = 1'b0;
                        state_d   = S_IDLE;
                    end else if (flush_i) begin
                        state_d = S_DISCARD;
                    end
                end
            end
            S_HOLD: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else if (!id_stall_i) begin
                    release_w    = 1'b1;
                    inst_d       = buf_q;
                    inst_pc_d    = mem_addr_q;
                    inst_valid_d = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            S_DISCARD: begin
                // The redirected-away response must still be absorbed before a new request
                if (mem_ack_i) begin
                    mem_req_d = 1'b0;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_inc_w;
                    if (timeout_w) begin
                        err_d     = 1'b1;
                        mem_req_d = 1'b0;
                        state_d   = S_IDLE;
                    end
                end
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= S_IDLE;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= 32'd0;
            inst_q       <= NOP_INST;
            inst_pc_q    <= 32'd0;
            inst_valid_q <= 1'b0;
            err_q        <= 1'b0;
            cnt_q        <= 8'd0;
            buf_q        <= 32'd0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
            buf_q        <= buf_d;
        end
    end

    assign stall_o      = start_i & ~flush_i & ~release_w;
    assign mem_req_o    = mem_req_q;
    assign mem_addr_o   = mem_addr_q;
    assign inst_o       = inst_q;
    assign inst_pc_o    = inst_pc_q;
    assign inst_valid_o = inst_valid_q;
    assign err_o        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// Testbench for ifetch_unit: latency-programmable memory responder plus a
// delivery scoreboard keyed on {inst_pc, inst}.
module tb_ifetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [31:0] pc_i;
    logic        flush_i;
    logic        id_stall_i;
    logic        mem_ack_i;
    logic [31:0] mem_data_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        stall_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_valid_o;
    logic        err_o;

    logic        resp_ack, force_ack, mem_en;
    logic [31:0] resp_data, force_data;
    int          ack_lat, wait_cnt;
    int          total = 0;
    int          bad = 0;
    logic [63:0] exp_q[$];

    assign mem_ack_i  = resp_ack | force_ack;
    assign mem_data_i = force_ack ? force_data : resp_data;

    always #5 clk_i = ~clk_i;

    ifetch_unit #(.NOP_INST(NOP), .MAX_WAIT(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .pc_i(pc_i),
        .flush_i(flush_i), .id_stall_i(id_stall_i), .mem_ack_i(mem_ack_i),
        .mem_data_i(mem_data_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .stall_o(stall_o), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
        .inst_valid_o(inst_valid_o), .err_o(err_o)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h8C01_0044;
    endfunction

    // Memory model: acks after ack_lat no-ack request cycles
    initial begin
        resp_ack = 1'b0; resp_data = 32'hDEAD_BEEF; wait_cnt = 0;
        forever begin
            @(posedge clk_i); #1;
            if (mem_req_o && mem_en) begin
                if (wait_cnt >= ack_lat) begin
                    resp_ack = 1'b1; resp_data = mem_word(mem_addr_o); wait_cnt = 0;
                end else begin
                    resp_ack = 1'b0; resp_data = 32'hDEAD_BEEF; wait_cnt++;
                end
            end else begin
                resp_ack = 1'b0; resp_data = 32'hDEAD_BEEF; wait_cnt = 0;
            end
        end
    end

    // Scoreboard: every delivery must match the oldest expectation; otherwise NOP
    always @(negedge clk_i) begin
        if (rst_i === 1'b1) begin
            total++;
            if (inst_valid_o) begin
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL sb_unexpected got pc=%h inst=%h required=no delivery", inst_pc_o, inst_o);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    if ({inst_pc_o, inst_o} !== e) begin
                        bad++; $display("FAIL sb_data got pc=%h inst=%h required pc=%h inst=%h", inst_pc_o, inst_o, e[63:32], e[31:0]);
                    end
                end
            end else if (inst_o !== NOP) begin
                bad++; $display("FAIL sb_nop got inst=%h required=%h", inst_o, NOP);
            end
        end
    end

    task automatic tick();
        @(posedge clk_i); #1;
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_q.push_back({pc, mem_word(pc)});
    endtask

    task automatic test_reset();
        rst_i = 1'b0; start_i = 1'b0; flush_i = 1'b0; id_stall_i = 1'b0; pc_i = 32'h1234;
        force_ack = 1'b0; force_data = 32'd0; mem_en = 1'b1; ack_lat = 0;
        @(negedge clk_i);
        total++; if (mem_req_o !== 1'b0)    begin bad++; $display("FAIL rst_req got=%b req=0", mem_req_o); end
        total++; if (mem_addr_o !== 32'd0)  begin bad++; $display("FAIL rst_addr got=%h req=0", mem_addr_o); end
        total++; if (inst_o !== NOP)        begin bad++; $display("FAIL rst_inst got=%h req=%h", inst_o, NOP); end
        total++; if (inst_pc_o !== 32'd0)   begin bad++; $display("FAIL rst_inst_pc got=%h req=0", inst_pc_o); end
        total++; if (inst_valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b req=0", inst_valid_o); end
        total++; if (err_o !== 1'b0)        begin bad++; $display("FAIL rst_err got=%b req=0", err_o); end
        total++; if (stall_o !== 1'b0)      begin bad++; $display("FAIL rst_stall got=%b req=0", stall_o); end
        tick(); rst_i = 1'b1;
    endtask

    task automatic test_basic();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            total++; if (stall_o !== 1'b0)   begin bad++; $display("FAIL idle_stall cyc=%0d got=%b req=0", i, stall_o); end
            total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL idle_req cyc=%0d got=%b req=0", i, mem_req_o); end
            tick();
        end
        start_i = 1'b1; pc_i = 32'h40; ack_lat = 2; push_exp(32'h40);
        @(negedge clk_i);
        total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL first_req_early got=%b req=0", mem_req_o); end
        total++; if (stall_o !== 1'b1)   begin bad++; $display("FAIL basic_stall0 got=%b req=1", stall_o); end
        tick(); pc_i = 32'h44;
        @(negedge clk_i);
        total++; if (mem_req_o !== 1'b1)     begin bad++; $display("FAIL basic_req got=%b req=1", mem_req_o); end
        total++; if (mem_addr_o !== 32'h40)  begin bad++; $display("FAIL basic_addr got=%h req=40", mem_addr_o); end
        total++; if (stall_o !== 1'b1)       begin bad++; $display("FAIL basic_stall1 got=%b req=1", stall_o); end
        tick();
        @(negedge clk_i);
        total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL basic_stall2 got=%b req=1", stall_o); end
        tick();
        @(negedge clk_i);
        total++; if (mem_ack_i !== 1'b1)    begin bad++; $display("FAIL basic_ack_cycle got=%b req=1", mem_ack_i); end
        total++; if (stall_o !== 1'b0)      begin bad++; $display("FAIL basic_stall_ack got=%b req=0", stall_o); end
        total++; if (mem_addr_o !== 32'h40) begin bad++; $display("FAIL basic_addr_hold got=%h req=40", mem_addr_o); end
        tick(); start_i = 1'b0;
        @(negedge clk_i);
        total++; if (inst_valid_o !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b req=1", inst_valid_o); end
        tick();
        @(negedge clk_i);
        total++; if (inst_valid_o !== 1'b0) begin bad++; $display("FAIL basic_valid_pulse got=%b req=0", inst_valid_o); end
        total++; if (mem_req_o !== 1'b0)    begin bad++; $display("FAIL basic_req_drop got=%b req=0", mem_req_o); end
        tick();
    endtask

    task automatic test_hold();
        start_i = 1'b1; pc_i = 32'h80; id_stall_i = 1'b1; ack_lat = 0; push_exp(32'h80);
        @(negedge clk_i); tick();
        @(negedge clk_i);
        total++; if (mem_ack_i !== 1'b1) begin bad++; $display("FAIL hold_ack got=%b req=1", mem_ack_i); end
        total++; if (stall_o !== 1'b1)   begin bad++; $display("FAIL hold_stall_ack got=%b req=1", stall_o); end
        tick(); force_ack = 1'b1; force_data = 32'hBAD0_BAD0;
        @(negedge clk_i);
        total++; if (stall_o !== 1'b1)      begin bad++; $display("FAIL hold_stall got=%b req=1", stall_o); end
        total++; if (inst_valid_o !== 1'b0) begin bad++; $display("FAIL hold_valid got=%b req=0", inst_valid_o); end
        total++; if (mem_req_o !== 1'b0)    begin bad++; $display("FAIL hold_req got=%b req=0", mem_req_o); end
        tick(); force_ack = 1'b0; id_stall_i = 1'b0;
        @(negedge clk_i);
        total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL hold_release got=%b req=0", stall_o); end
        tick(); start_i = 1'b0;
        @(negedge clk_i);
        total++; if (inst_valid_o !== 1'b1) begin bad++; $display("FAIL hold_deliver got=%b req=1", inst_valid_o); end
        tick();
    endtask

    task automatic test_flush();
        start_i = 1'b1; pc_i = 32'h100; ack_lat = 3;
        @(negedge clk_i); tick();
        @(negedge clk_i); tick();
        flush_i = 1'b1; pc_i = 32'h200;
        @(negedge clk_i);
        total++; if (stall_o !== 1'b0)   begin bad++; $display("FAIL flush_stall got=%b req=0", stall_o); end
        total++; if (mem_req_o !== 1'b1) begin bad++; $display("FAIL flush_req got=%b req=1", mem_req_o); end
        tick(); flush_i = 1'b0;
        @(negedge clk_i);
        total++; if (stall_o !== 1'b1)       begin bad++; $display("FAIL discard_stall got=%b req=1", stall_o); end
        total++; if (mem_addr_o !== 32'h100) begin bad++; $display("FAIL discard_addr got=%h req=100", mem_addr_o); end
        tick();
        @(negedge clk_i);
        total++; if (mem_ack_i !== 1'b1 || mem_req_o !== 1'b1) begin bad++; $display("FAIL discard_ack got ack=%b req=%b required 1/1", mem_ack_i, mem_req_o); end
        tick(); ack_lat = 0; push_exp(32'h200);
        @(negedge clk_i);
        total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL discard_idle_req got=%b req=0", mem_req_o); end
        tick();
        @(negedge clk_i);
        total++; if (mem_addr_o !== 32'h200) begin bad++; $display("FAIL redirect_addr got=%h req=200", mem_addr_o); end
        tick(); start_i = 1'b0;
        @(negedge clk_i); tick();
        // Flush coinciding with the ack drops the word
        start_i = 1'b1; pc_i = 32'h500;
        @(negedge clk_i); tick();
        flush_i = 1'b1;
        @(negedge clk_i);
        total++; if (mem_ack_i !== 1'b1 || stall_o !== 1'b0) begin bad++; $display("FAIL flush_ack got ack=%b stall=%b required 1/0", mem_ack_i, stall_o); end
        tick(); flush_i = 1'b0; start_i = 1'b0;
        @(negedge clk_i);
        total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL flush_ack_req got=%b req=0", mem_req_o); end
        tick();
    endtask

    task automatic test_back_to_back();
        start_i = 1'b1; ack_lat = 1;
        for (int k = 0; k < 4; k++) begin
            pc_i = 32'h1000 + 32'(k * 4); push_exp(pc_i);
            @(negedge clk_i);
            total++; if (inst_valid_o !== 1'(k > 0)) begin bad++; $display("FAIL b2b_valid k=%0d got=%b", k, inst_valid_o); end
            tick();
            @(negedge clk_i);
            total++; if (inst_valid_o !== 1'b0) begin bad++; $display("FAIL b2b_gap k=%0d got=%b req=0", k, inst_valid_o); end
            tick();
            @(negedge clk_i);
            total++; if (mem_ack_i !== 1'b1) begin bad++; $display("FAIL b2b_ack k=%0d got=%b req=1", k, mem_ack_i); end
            tick();
        end
        start_i = 1'b0;
        @(negedge clk_i);
        total++; if (inst_valid_o !== 1'b1) begin bad++; $display("FAIL b2b_last got=%b req=1", inst_valid_o); end
        tick();
    endtask

    task automatic test_timeout();
        mem_en = 1'b0; start_i = 1'b1; pc_i = 32'h300;
        @(negedge clk_i); tick();
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk_i);
            total++; if (mem_req_o !== 1'b1 || err_o !== 1'b0) begin bad++; $display("FAIL to_wait cyc=%0d got req=%b err=%b required 1/0", i, mem_req_o, err_o); end
            tick();
        end
        start_i = 1'b0;
        @(negedge clk_i);
        total++; if (err_o !== 1'b1)     begin bad++; $display("FAIL to_err got=%b req=1", err_o); end
        total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL to_req got=%b req=0", mem_req_o); end
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            total++; if (err_o !== 1'b1) begin bad++; $display("FAIL to_sticky cyc=%0d got=%b req=1", i, err_o); end
            tick();
        end
        mem_en = 1'b1;
    endtask

    task automatic test_async_reset();
        start_i = 1'b1; pc_i = 32'h400; ack_lat = 2;
        @(negedge clk_i); tick();
        @(negedge clk_i);
        total++; if (mem_req_o !== 1'b1) begin bad++; $display("FAIL ar_req_pre got=%b req=1", mem_req_o); end
        tick(); #2 rst_i = 1'b0; #1;
        total++; if (mem_req_o !== 1'b0)    begin bad++; $display("FAIL ar_req got=%b req=0", mem_req_o); end
        total++; if (mem_addr_o !== 32'd0)  begin bad++; $display("FAIL ar_addr got=%h req=0", mem_addr_o); end
        total++; if (err_o !== 1'b0)        begin bad++; $display("FAIL ar_err got=%b req=0", err_o); end
        total++; if (inst_pc_o !== 32'd0)   begin bad++; $display("FAIL ar_inst_pc got=%h req=0", inst_pc_o); end
        total++; if (inst_o !== NOP || inst_valid_o !== 1'b0) begin bad++; $display("FAIL ar_inst got inst=%h valid=%b", inst_o, inst_valid_o); end
        start_i = 1'b0; force_ack = 1'b1; force_data = 32'hCAFE_F00D;
        tick(); tick(); rst_i = 1'b1;
        tick(); force_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            total++; if (mem_req_o !== 1'b0 || inst_valid_o !== 1'b0) begin bad++; $display("FAIL ar_late_ack got req=%b valid=%b required 0/0", mem_req_o, inst_valid_o); end
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time bound expired");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_flush();
        test_back_to_back();
        test_timeout();
        test_async_reset();
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d required=0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
